// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared data-memory op encoding, arbiter states and access-fault helper
//
// Used by the arbiter and by the data memory so both agree on the op encoding.
//   mem_op_e     : LB..SW encoded 0..7; codes 5..7 are stores
//   arb_state_e  : arbiter transaction phases
//   op_is_store  : 1 for SB/SH/SW
//   access_fault : 1 when an access must not reach memory
package dmem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Misaligned halfword/word, beyond the last byte of memory, or a store
  // flag that disagrees with the op direction.
  function automatic logic access_fault(input logic [2:0]  op,
                                        input logic        we,
                                        input logic [31:0] addr,
                                        input int unsigned mem_size);
    logic        misal;
    logic        oor;
    logic        mism;
    logic [33:0] limit;
    misal = 1'b0;
    case (mem_op_e'(op))
      OP_LH, OP_LHU, OP_SH: misal = addr[0];
      OP_LW, OP_SW:         misal = |addr[1:0];
      default:              misal = 1'b0;
    endcase
    limit = 34'(mem_size) << 2;
    oor   = ({2'b00, addr} >= limit);
    mism  = (we != op_is_store(op));
    return misal | oor | mism;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant selection
//
// Ports:
//   valid[1:0]  : request valids
//   last_grant  : index of the requester granted most recently
//   grant[1:0]  : one-hot grant (zero when nothing is valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_grant)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of a single-port data memory
//
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   req_valid/req_ready[1:0]         : per-requester handshake (0 = core LSU, 1 = DMA/debug)
//   req_we[1:0], req_op0/1           : store flag and op code (mem_op_e)
//   req_addr0/1, req_wdata0/1        : byte address and store data
//   rsp_valid[1:0], rsp_rdata, rsp_err : one-cycle response to the granted requester
//   mem_read, mem_write              : one-cycle memory strobes
//   mem_addr, mem_fun3, mem_wdata    : latched request payload toward memory
//   mem_rdata                        : load data from memory, valid during the read strobe
import dmem_pkg::*;

module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_fun3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        idx_q, idx_d;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [1:0]  grant;
  logic        sel_we;
  logic [2:0]  sel_op;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign sel_we    = grant[1] ? req_we[1]  : req_we[0];
  assign sel_op    = grant[1] ? req_op1    : req_op0;
  assign sel_addr  = grant[1] ? req_addr1  : req_addr0;
  assign sel_wdata = grant[1] ? req_wdata1 : req_wdata0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    we_d         = we_q;
    fault_d      = fault_q;
    addr_d       = addr_q;
    fun3_d       = fun3_q;
    wdata_d      = wdata_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 2'b00;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    rsp_valid    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|grant) begin
          state_d      = ST_ACCESS;
          last_grant_d = grant[1];
          idx_d        = grant[1];
          we_d         = sel_we;
          fun3_d       = sel_op;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          // Fault decided once at grant so the access phase only gates strobes.
          fault_d      = access_fault(sel_op, sel_we, sel_addr, MEM_SIZE);
        end
      end
      ST_ACCESS: begin
        mem_read    = !fault_q && !we_q;
        mem_write   = !fault_q && we_q;
        rsp_err_d   = fault_q;
        rsp_rdata_d = (fault_q || we_q) ? 32'd0 : mem_rdata;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = idx_q ? 2'b10 : 2'b01;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      addr_q       <= 32'd0;
      fun3_q       <= 3'd0;
      wdata_q      <= 32'd0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      fault_q      <= fault_d;
      addr_q       <= addr_d;
      fun3_q       <= fun3_d;
      wdata_q      <= wdata_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_fun3  = fun3_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized check of dmem_arbiter against a transaction model
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MEM_SIZE = 1024;
  localparam int NBYTES   = 4 * MEM_SIZE;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_valid [2];
  logic        t_we    [2];
  logic [2:0]  t_op    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];

  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        rsp_err, mem_read, mem_write;
  logic [2:0]  mem_fun3;

  assign req_valid = {t_valid[1], t_valid[0]};
  assign req_we    = {t_we[1], t_we[0]};

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op0(t_op[0]), .req_op1(t_op[1]),
    .req_addr0(t_addr[0]), .req_addr1(t_addr[1]),
    .req_wdata0(t_wdata[0]), .req_wdata1(t_wdata[1]),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_fun3(mem_fun3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached data memory: combinational, lane-extracting read; byte-lane write.
  logic [31:0] dmem [MEM_SIZE];

  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = dmem[mem_addr[11:2]];
    b = w[{mem_addr[1:0], 3'b000} +: 8];
    h = mem_addr[1] ? w[31:16] : w[15:0];
    case (mem_fun3)
      OP_LB:   mem_rdata = {{24{b[7]}}, b};
      OP_LBU:  mem_rdata = {24'd0, b};
      OP_LH:   mem_rdata = {{16{h[15]}}, h};
      OP_LHU:  mem_rdata = {16'd0, h};
      default: mem_rdata = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_fun3)
        OP_SB: dmem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        OP_SH: begin
          if (mem_addr[1]) dmem[mem_addr[11:2]][31:16] <= mem_wdata[15:0];
          else             dmem[mem_addr[11:2]][15:0]  <= mem_wdata[15:0];
        end
        default: dmem[mem_addr[11:2]] <= mem_wdata;
      endcase
    end
  end

  // Reference: byte-addressed memory image updated at grant time.
  logic [7:0] mm [NBYTES];

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  function automatic logic m_fault(input logic [2:0] op, input logic we, input logic [31:0] a);
    if (a >= 32'(NBYTES)) return 1'b1;
    if (we != (op >= 3'd5)) return 1'b1;
    if ((op == 3'd2 || op == 3'd3 || op == 3'd6) && a[0]) return 1'b1;
    if ((op == 3'd4 || op == 3'd7) && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd0:    return {{24{mm[a][7]}}, mm[a]};
      3'd1:    return {24'd0, mm[a]};
      3'd2:    return {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
      3'd3:    return {16'd0, mm[a+1], mm[a]};
      3'd4:    return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    mm[a] = d[7:0];
    if (op >= 3'd6) mm[a+1] = d[15:8];
    if (op == 3'd7) begin
      mm[a+2] = d[23:16];
      mm[a+3] = d[31:24];
    end
  endtask

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model timeline: a grant in cycle g means a strobe in g+1, a response in
  // g+2, and the next grant no earlier than g+3.
  int          m_free, m_last, pend_rd, pend_wr, pend_rsp, pend_port;
  logic        pend_err;
  logic [31:0] pend_data, m_addr, m_wdata;
  logic [2:0]  m_fun3;
  int          rsp_count = 0, wr_count = 0, rd_cyc = -1, last_rsp_cyc = -1, last_rsp_port = -1;
  logic [31:0] last_rsp_data;
  logic        last_rsp_err;
  int          grant_log [$];

  always @(negedge clk) begin : cmp
    int       w;
    logic     f;
    logic [1:0] er, ersp;
    if (reset) begin
      m_free = cyc + 1; m_last = 1;
      pend_rd = -1; pend_wr = -1; pend_rsp = -1; pend_port = 0;
      m_addr = 32'd0; m_fun3 = 3'd0; m_wdata = 32'd0;
    end else begin
      check("mem_addr_hold", mem_addr, m_addr);
      check("mem_fun3_hold", 32'(mem_fun3), 32'(m_fun3));
      check("mem_wdata_hold", mem_wdata, m_wdata);
      er = 2'b00;
      w  = 0;
      if (cyc >= m_free && (t_valid[0] || t_valid[1])) begin
        if (t_valid[0] && t_valid[1]) w = 1 - m_last;
        else                          w = t_valid[1] ? 1 : 0;
        er = (w == 1) ? 2'b10 : 2'b01;
      end
      check("req_ready", 32'(req_ready), 32'(er));
      check("mem_read", 32'(mem_read), 32'(cyc == pend_rd));
      check("mem_write", 32'(mem_write), 32'(cyc == pend_wr));
      ersp = (cyc == pend_rsp) ? ((pend_port == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("rsp_valid", 32'(rsp_valid), 32'(ersp));
      if (cyc == pend_rsp) begin
        check("rsp_rdata", rsp_rdata, pend_data);
        check("rsp_err", 32'(rsp_err), 32'(pend_err));
      end
      if (rsp_valid != 2'b00) begin
        rsp_count++;
        last_rsp_cyc  = cyc;
        last_rsp_port = rsp_valid[1] ? 1 : 0;
        last_rsp_data = rsp_rdata;
        last_rsp_err  = rsp_err;
      end
      if (mem_write) wr_count++;
      if (mem_read) rd_cyc = cyc;
      if (req_ready != 2'b00) grant_log.push_back(req_ready[1] ? 1 : 0);
      if (er != 2'b00) begin
        f         = m_fault(t_op[w], t_we[w], t_addr[w]);
        m_free    = cyc + 3;
        m_last    = w;
        m_addr    = t_addr[w];
        m_fun3    = t_op[w];
        m_wdata   = t_wdata[w];
        pend_rsp  = cyc + 2;
        pend_port = w;
        pend_err  = f;
        pend_rd   = (!f && !t_we[w]) ? cyc + 1 : -1;
        pend_wr   = (!f &&  t_we[w]) ? cyc + 1 : -1;
        pend_data = (f || t_we[w]) ? 32'd0 : m_load(t_op[w], t_addr[w]);
        if (!f && t_we[w]) m_store(t_op[w], t_addr[w], t_wdata[w]);
      end
    end
  end

  // Caller must be just after a rising edge; returns just after the edge that
  // accepted the request, with valid dropped (unless the caller re-issues).
  task automatic issue(input int p, input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d, output int g);
    int n;
    t_valid[p] = 1'b1; t_we[p] = we; t_op[p] = op; t_addr[p] = a; t_wdata[p] = d;
    n = 0;
    g = -1;
    while (g < 0) begin
      @(negedge clk);
      if (req_ready[p]) begin
        g = cyc;
      end else begin
        n++;
        if (n > 40) begin
          total++; bad++;
          $display("FAIL grant_timeout: port %0d got no ready after %0d cycles, wanted a grant", p, n);
          break;
        end
      end
    end
    @(posedge clk); #1;
    t_valid[p] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_rsp(input string nm, input int g, input int port,
                           input logic [31:0] data, input logic err);
    check({nm, "_cyc"}, 32'(last_rsp_cyc), 32'(g + 2));
    check({nm, "_port"}, 32'(last_rsp_port), 32'(port));
    check({nm, "_rdata"}, last_rsp_data, data);
    check({nm, "_err"}, 32'(last_rsp_err), 32'(err));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({nm, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({nm, "_mem_rw"}, 32'({mem_read, mem_write}), 32'd0);
    check({nm, "_mem_addr"}, mem_addr, 32'd0);
    check({nm, "_mem_fun3"}, 32'(mem_fun3), 32'd0);
    check({nm, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic rnd_driver(input int p, input int n);
    int          g;
    logic [2:0]  op;
    logic        we;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      we = (op >= 3'd5);
      if ($urandom_range(0, 9) == 0) we = !we;
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 15));
        1:       a = 32'hFF0 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 63));
      endcase
      issue(p, we, op, a, $urandom, g);
      wait_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, ga, gb, gc, gd, wc, rc;
    reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      t_valid[p] = 1'b0; t_we[p] = 1'b0; t_op[p] = 3'd0; t_addr[p] = 32'd0; t_wdata[p] = 32'd0;
    end
    for (int i = 0; i < MEM_SIZE; i++) begin
      logic [31:0] w;
      w = init_word(i);
      dmem[i] = w;
      for (int k = 0; k < 4; k++) mm[4*i+k] = w[8*k +: 8];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;

    // Contention from reset: port 0 first, port 1 three cycles later.
    fork
      issue(0, 1'b0, OP_LW, 32'h10, 32'd0, g0);
      issue(1, 1'b0, OP_LW, 32'h20, 32'd0, g1);
    join
    wait_cycles(2);
    check("contend_spacing", 32'(g1 - g0), 32'd3);
    check_rsp("contend_p1", g1, 1, 32'hC0DE0008, 1'b0);

    // Single load of word 4.
    issue(0, 1'b0, OP_LW, 32'h10, 32'd0, g0);
    wait_cycles(2);
    check("load_rd_cyc", 32'(rd_cyc), 32'(g0 + 1));
    check_rsp("load", g0, 0, 32'hDEADBEEF, 1'b0);

    // Misaligned word store from port 1.
    wc = wr_count;
    issue(1, 1'b1, OP_SW, 32'h6, 32'h12345678, g1);
    wait_cycles(2);
    check("misal_no_write", 32'(wr_count), 32'(wc));
    check_rsp("misal", g1, 1, 32'd0, 1'b1);

    // Out of range, then last byte of memory.
    issue(0, 1'b0, OP_LB, 32'h1000, 32'd0, g0);
    wait_cycles(2);
    check_rsp("oor", g0, 0, 32'd0, 1'b1);
    wc = wr_count;
    issue(0, 1'b1, OP_SB, 32'hFFF, 32'h000000AB, g0);
    wait_cycles(2);
    check("sb_one_write", 32'(wr_count), 32'(wc + 1));
    check_rsp("sb_top", g0, 0, 32'd0, 1'b0);
    issue(0, 1'b0, OP_LBU, 32'hFFF, 32'd0, g0);
    wait_cycles(2);
    check_rsp("lbu_top", g0, 0, 32'h000000AB, 1'b0);
    issue(0, 1'b0, OP_LB, 32'hFFF, 32'd0, g0);
    wait_cycles(2);
    check_rsp("lb_top", g0, 0, 32'hFFFFFFAB, 1'b0);

    // Store flag with a load op: fault, memory untouched.
    wc = wr_count;
    issue(0, 1'b1, OP_LH, 32'h20, 32'h0000FFFF, g0);
    wait_cycles(2);
    check("mism_no_write", 32'(wr_count), 32'(wc));
    check_rsp("mism", g0, 0, 32'd0, 1'b1);
    issue(0, 1'b0, OP_LW, 32'h20, 32'd0, g0);
    wait_cycles(2);
    check_rsp("mism_after", g0, 0, 32'hC0DE0008, 1'b0);

    // Reset during the access phase of a port-0 load.
    issue(0, 1'b0, OP_LW, 32'h10, 32'd0, g0);
    rc = rsp_count;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    wait_cycles(2);
    check("midrst_no_rsp", 32'(rsp_count), 32'(rc));

    // Persistent contention after reset: 0,1,0,1.
    grant_log.delete();
    fork
      begin
        issue(0, 1'b0, OP_LW, 32'h10, 32'd0, ga);
        issue(0, 1'b0, OP_LW, 32'h14, 32'd0, gc);
      end
      begin
        issue(1, 1'b0, OP_LW, 32'h20, 32'd0, gb);
        issue(1, 1'b0, OP_LW, 32'h24, 32'd0, gd);
      end
    join
    wait_cycles(2);
    check("alt_len", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check("alt_0", 32'(grant_log[0]), 32'd0);
      check("alt_1", 32'(grant_log[1]), 32'd1);
      check("alt_2", 32'(grant_log[2]), 32'd0);
      check("alt_3", 32'(grant_log[3]), 32'd1);
    end
    check("alt_gap", 32'(gd - ga), 32'd9);
    check_rsp("alt_last", gd, 1, 32'hC0DE0009, 1'b0);

    // Randomized traffic on both ports.
    fork
      rnd_driver(0, 80);
      rnd_driver(1, 80);
    join
    wait_cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, meaning number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req_valid[1:0], input, 2, per-requester request valid (index 0 = core LSU, index 1 = DMA/debug).
REQ-005 SHALL have ports req_ready[1:0], output, 2, per-requester accept strobe.
REQ-006 SHALL have ports req_we[1:0], input, 2, per-requester store flag.
REQ-007 SHALL have ports req_op0/req_op1, input, 3 each, memory op code (LB, LBU, LH, LHU, LW, SB, SH, SW encoding 0..7).
REQ-008 SHALL have ports req_addr0/req_addr1 and req_wdata0/req_wdata1, input, 32 each, byte address and store data.
REQ-009 SHALL have ports rsp_valid[1:0], output, 2, one-cycle response strobe per requester.
REQ-010 SHALL have ports rsp_rdata, output, 32, load data, and rsp_err, output, 1, access fault; both qualified by rsp_valid.
REQ-011 SHALL have memory-side outputs mem_read (1), mem_write (1), mem_addr (32), mem_fun3 (3), mem_wdata (32), and input mem_rdata (32).

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP always, RESP->IDLE always.
REQ-013 In IDLE with any req_valid set, SHALL assert req_ready for exactly one winner in that same cycle (combinational) and latch its we/op/addr/wdata and index.
REQ-014 Arbitration: one valid wins; both valid -> requester not granted last; last_grant resets to 1 so requester 0 wins first contention.
REQ-015 req_ready SHALL be 0 in ACCESS and RESP; requesters hold valid and payload until ready.
REQ-016 In ACCESS, SHALL drive mem_addr/mem_fun3/mem_wdata from latched payload and assert mem_read (load) or mem_write (store) for exactly one cycle, unless faulted.
REQ-017 At the ACCESS->RESP edge, SHALL register mem_rdata into rsp_rdata for loads; stores return rsp_rdata = 0.
REQ-018 In RESP, SHALL assert rsp_valid[idx] for exactly one cycle with rsp_err; latency grant-to-response = 2 cycles; peak throughput one access per 3 cycles.
REQ-019 Fault if: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; addr >= 4*MEM_SIZE; req_we=1 with load op or req_we=0 with store op.
REQ-020 Faulted access SHALL keep mem_read/mem_write low in ACCESS, return rsp_err=1, rsp_rdata=0, and still update last_grant.
REQ-021 Outside ACCESS, mem_read and mem_write SHALL be 0; mem_addr/mem_fun3/mem_wdata hold latched values.
REQ-022 A new req_valid arriving during ACCESS/RESP SHALL wait; no request is dropped or duplicated.

Reset
REQ-023 reset SHALL force state IDLE, last_grant=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_fun3=0, mem_wdata=0.
REQ-024 reset asserted mid-transaction SHALL abandon it with no response and no further memory strobe after the reset edge.

Structure
REQ-025 The memory op enum (LB..SW) and fault-check helper SHALL live in shared package dmem_pkg, also imported by the data memory.
REQ-026 Round-robin selection SHALL be sub-module rr_arbiter2 (inputs valid[1:0], last_grant; output one-hot grant).

Verification
REQ-027 Single load: port0 LW addr 0x10, mem word 4 = 0xDEADBEEF -> ready0 cycle 0, mem_read cycle 1, rsp_valid0 cycle 2, rdata 0xDEADBEEF, err 0.
REQ-028 Contention: both valid from reset -> port0 served first, port1 next; persistently both valid -> alternation 0,1,0,1.
REQ-029 Misaligned: port1 SW addr 0x6 -> no mem_write, rsp_valid1 with rsp_err=1, rdata 0.
REQ-030 Out of range: LB addr 0x1000 (MEM_SIZE 1024) -> rsp_err=1; SB addr 0xFFF data 0xAB then LBU same addr -> rdata 0x000000AB.
REQ-031 Reset in ACCESS: reset high one cycle -> no rsp_valid, all outputs at reset values, next request serviced normally by port0.
REQ-032 Op/we mismatch: req_we=1 with LH -> rsp_err=1, memory unchanged.
